// File: rtl/axis_switch_pkg.sv
// axis_switch_pkg: shared types and helpers for the AXI-Stream switch egress arbiter.
package axis_switch_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_rr_grant.sv
// axis_rr_grant: round-robin next-grant search (rotate, priority encode, un-rotate).
module axis_rr_grant #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] idx,
  output logic             any_req
);
  logic [N-1:0] rot;
  int start, off;
  always_comb begin
    start = (int'(last_grant) + 1) % N;
    rot = '0;
    for (int k = 0; k < N; k++) rot[k] = req[(start + k) % N];
    off = 0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = k;
    idx = SEL_W'((start + off) % N);
  end
  assign any_req = |req;
endmodule

// File: rtl/axis_rr_arbiter_mux.sv
// axis_rr_arbiter_mux: packet-locked round-robin N:1 AXI-Stream arbiter with data mux
// and registered output slice, tagging each beat with its source index.
module axis_rr_arbiter_mux
  import axis_switch_pkg::*;
#(
  parameter int AMOUNT_IN  = 4,
  parameter int WIDTH_DATA = 32,
  parameter int SEL_W      = sel_width(AMOUNT_IN)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [AMOUNT_IN-1:0][WIDTH_DATA-1:0] s_tdata_i,
  input  logic [AMOUNT_IN-1:0]                s_tvalid_i,
  input  logic [AMOUNT_IN-1:0]                s_tlast_i,
  output logic [AMOUNT_IN-1:0]                s_tready_o,
  output logic [WIDTH_DATA-1:0]               m_tdata_o,
  output logic                                m_tvalid_o,
  output logic                                m_tlast_o,
  output logic [SEL_W-1:0]                    m_tid_o,
  input  logic                                m_tready_i
);
  state_t state, state_nx;
  logic [SEL_W-1:0] sel, last_grant, grant_idx;
  logic any_req, out_free, in_hs, pkt_end;

  axis_rr_grant #(.N(AMOUNT_IN), .SEL_W(SEL_W)) u_grant (
    .req       (s_tvalid_i),
    .last_grant(last_grant),
    .idx       (grant_idx),
    .any_req   (any_req)
  );

  // ready is derived only from state and the output slice, never from tvalid
  assign out_free   = !m_tvalid_o || m_tready_i;
  assign s_tready_o = (state == LOCKED && out_free) ? AMOUNT_IN'(1) << sel : '0;
  assign in_hs      = s_tvalid_i[sel] && s_tready_o[sel];
  assign pkt_end    = in_hs && s_tlast_i[sel];

  always_comb
    state_nx = (state == IDLE) ? (any_req ? LOCKED : IDLE) : (pkt_end ? IDLE : LOCKED);

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= SEL_W'(AMOUNT_IN - 1);
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) sel <= grant_idx;
      if (pkt_end) last_grant <= sel;
    end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tid_o    <= '0;
    end else if (in_hs) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= s_tdata_i[sel];
      m_tlast_o  <= s_tlast_i[sel];
      m_tid_o    <= sel;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
endmodule
